// File: rtl/ex_mem_pipeline_reg.sv
// EX/MEM pipeline register: carries control bits, ALU result, store data and destination register into Memory.
// Latency: one cycle from accept to Memory-stage outputs, when the main entry is empty or being consumed.
// Backpressure: out_ready low holds the entry; SKID=1 absorbs one extra entry and drops a registered in_ready.
module ex_mem_pipeline_reg #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int SKID   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              flush,
  input  logic              RegWriteE,
  input  logic              MemtoRegE,
  input  logic              MemWriteE,
  input  logic [DATA_W-1:0] ALUOutE,
  input  logic [DATA_W-1:0] WriteDataE,
  input  logic [REG_W-1:0]  WriteRegE,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              RegWriteM,
  output logic              MemtoRegM,
  output logic              MemWriteM,
  output logic [DATA_W-1:0] ALUOutM,
  output logic [DATA_W-1:0] WriteDataM,
  output logic [REG_W-1:0]  WriteRegM,
  output logic [1:0]        occupancy
);

  // One complete stage payload; the same layout is used for the main and skid entries.
  typedef struct packed {
    logic              regWrite;
    logic              memtoReg;
    logic              memWrite;
    logic [DATA_W-1:0] aluOut;
    logic [DATA_W-1:0] writeData;
    logic [REG_W-1:0]  writeReg;
  } entry_t;

  entry_t inEntry;
  entry_t mEntry;
  logic   mValid;
  logic   sValid;
  logic   accept;
  logic   consume;

  assign inEntry = {RegWriteE, MemtoRegE, MemWriteE, ALUOutE, WriteDataE, WriteRegE};
  assign accept  = in_valid && in_ready;
  assign consume = mValid && out_ready;

  generate
    if (SKID != 0) begin : g_skid
      entry_t sEntry;

      // in_ready depends only on the skid valid flop, so it never sees out_ready combinationally.
      assign in_ready = !sValid;

      // Valid bits: flush beats everything; a full skid entry drains into main before new data is taken.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          mValid <= 1'b0;
          sValid <= 1'b0;
        end else if (flush) begin
          mValid <= 1'b0;
          sValid <= 1'b0;
        end else if (sValid && consume) begin
          mValid <= 1'b1;
          sValid <= 1'b0;
        end else if (accept && (!mValid || consume)) begin
          mValid <= 1'b1;
        end else if (accept) begin
          sValid <= 1'b1;
        end else if (consume) begin
          mValid <= 1'b0;
        end
      end

      // Payload only moves on an actual transfer, so stalled entries do not toggle.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          mEntry <= '0;
          sEntry <= '0;
        end else if (!flush) begin
          if (sValid && consume) begin
            mEntry <= sEntry;
          end else if (accept && (!mValid || consume)) begin
            mEntry <= inEntry;
          end else if (accept) begin
            sEntry <= inEntry;
          end
        end
      end
    end else begin : g_single
      // Single entry: can take new data whenever the current one leaves this cycle.
      assign in_ready = out_ready || !mValid;
      assign sValid   = 1'b0;

      // Main valid bit: flush clears, accept sets, otherwise a consume empties.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          mValid <= 1'b0;
        end else if (flush) begin
          mValid <= 1'b0;
        end else if (accept) begin
          mValid <= 1'b1;
        end else if (consume) begin
          mValid <= 1'b0;
        end
      end

      // Main payload loads only on a surviving accept.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          mEntry <= '0;
        end else if (!flush && accept) begin
          mEntry <= inEntry;
        end
      end
    end
  endgenerate

  // Side-effecting controls are masked on bubbles; the rest of the payload simply holds.
  assign out_valid  = mValid;
  assign RegWriteM  = mValid && mEntry.regWrite;
  assign MemWriteM  = mValid && mEntry.memWrite;
  assign MemtoRegM  = mEntry.memtoReg;
  assign ALUOutM    = mEntry.aluOut;
  assign WriteDataM = mEntry.writeData;
  assign WriteRegM  = mEntry.writeReg;
  assign occupancy  = {1'b0, mValid} + {1'b0, sValid};

endmodule

// File: doc/ex_mem_pipeline_reg.md
# ex_mem_pipeline_reg

Parametrised, flow-controlled pipeline register between the Execute (ALU) and Memory (data memory) stages. It generalises the plain EX/MEM control register: it carries the full stage payload (control bits, ALU result, store data, destination register) and uses a valid/ready handshake with stall back-pressure and synchronous flush. An optional two-entry skid mode keeps full throughput while registering the upstream ready.

## Interface
Parameters:
- DATA_W, 32, width of ALU result and store data
- REG_W, 5, width of destination register index
- SKID, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single entry with combinational in_ready

Ports:
- clk  input  1  rising-edge clock; single clock domain
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  Execute stage presents a valid instruction
- in_ready  output  1  block accepts an input this cycle
- flush  input  1  synchronous kill of all held entries
- RegWriteE, MemtoRegE, MemWriteE  input  1 each  Execute control bits
- ALUOutE  input  DATA_W  ALU result
- WriteDataE  input  DATA_W  store data
- WriteRegE  input  REG_W  destination register
- out_valid  output  1  Memory-stage entry valid
- out_ready  input  1  Memory stage consumes the entry (low = stall)
- RegWriteM, MemtoRegM, MemWriteM  output  1 each  Memory control bits
- ALUOutM, WriteDataM  output  DATA_W  payload
- WriteRegM  output  REG_W  payload
- occupancy  output  2  entries held (0..2; max 1 when SKID=0)

## Operation
- Storage: main entry M (drives outputs) and, when SKID=1, skid entry S; each has a valid bit plus full payload.
- Accept = in_valid && in_ready; consume = out_valid && out_ready.
- in_ready: SKID=1 -> !S.valid (registered); SKID=0 -> out_ready || !M.valid (combinational).
- Next-state rules, SKID=1 (priority order):
  - flush: M.valid <= 0, S.valid <= 0; any accept that cycle is discarded.
  - S full and consume: M <= S, S.valid <= 0 (no accept possible).
  - accept and (M empty or consume): M <= input.
  - accept and M full and no consume: S <= input.
  - consume with nothing incoming: M.valid <= 0.
- SKID=0: flush clears M; else accept loads M; else consume clears M.valid.
- Control gating: RegWriteM and MemWriteM are driven 0 whenever out_valid = 0, so bubbles have no side effects. MemtoRegM and payload hold their last value when invalid.
- Payload registers load only on accept/transfer (no toggling during stall).
- occupancy = M.valid + S.valid.
- Order is strictly FIFO; no entry is duplicated or dropped except by flush.

## Timing
- Reset (rst_n low, async): M.valid = S.valid = 0; all control and payload registers 0; out_valid = 0; occupancy = 0; in_ready = 1 immediately after reset deassertion.
- Latency: input accepted at edge N appears on outputs after edge N (one cycle), when M was empty or consumed.
- Throughput: one per cycle with out_ready held high, both modes.
- Stall: out_ready low holds M outputs stable; SKID=1 accepts one more then drops in_ready the next cycle; SKID=0 drops in_ready in the same cycle.
- Simultaneous flush + accept + consume: flush wins; occupancy 0 next cycle.
- Reset mid-transfer: all entries lost, outputs 0 asynchronously.

## Test plan
- Reset: rst_n low mid-stream with occupancy 2 -> out_valid, RegWriteM, MemWriteM, ALUOutM, occupancy all 0 without a clock edge; in_ready = 1 after release.
- Streaming: 8 back-to-back inputs ALUOutE = 0x10..0x17, out_ready = 1 -> outputs 0x10..0x17 one cycle later, in order, no gaps, both SKID values.
- Stall/skid (SKID=1): out_ready low 3 cycles while feeding 0xA0, 0xA1, 0xA2 -> 0xA0 held, 0xA1 in skid, in_ready = 0, occupancy = 2; release -> 0xA0, 0xA1, 0xA2 delivered, none lost.
- Flush: occupancy 2 plus in_valid and out_ready all high with flush -> next cycle out_valid = 0, occupancy = 0, accepted input discarded.
- Bubble gating: in_valid = 0 with RegWriteE = MemWriteE = 1 -> RegWriteM = MemWriteM = 0, out_valid = 0.
- SKID=0 stall: out_ready = 0 with M full -> in_ready = 0 same cycle; WriteRegM = 5'd31, DATA_W = 64 payload 0xFFFF_0000_1234_5678 held stable.
